// File: rtl/aurora_rx_frame_checker.sv
// Receive-side checker for Aurora framing-mode frames: validates header/sequence,
// payload pattern, tkeep legality and frame length; keeps saturating statistics.
module aurora_rx_frame_checker #(
    parameter logic [15:0] HDR_MAGIC = 16'hCAFE,
    parameter logic [15:0] SEQ_INIT  = 16'h0000,
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             io_clk,
    input  logic             reset_n,
    input  logic             channel_up,
    input  logic             clr_cnt,
    input  logic [0:31]      rx_data,
    input  logic             rx_tvalid,
    input  logic [0:3]       rx_tkeep,
    input  logic             rx_tlast,
    output logic             frame_done,
    output logic             frame_good,
    output logic [CNT_W-1:0] frame_ok_cnt,
    output logic [CNT_W-1:0] frame_err_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic             err_data,
    output logic             err_seq,
    output logic             err_len,
    output logic             err_keep,
    output logic             err_abort,
    output logic [0:31]      first_bad
);

    typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DISCARD} state_t;

    localparam logic [15:0]      LP_MAX = 16'(MAX_WORDS);
    localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

    state_t           r_state;
    logic [15:0]      r_exp_seq, r_hdr_seq, r_k;
    logic             r_frm_err, r_frame_done, r_frame_good;
    logic [CNT_W-1:0] r_ok_cnt, r_err_cnt, r_word_cnt;
    logic             r_err_data, r_err_seq, r_err_len, r_err_keep, r_err_abort;
    logic [0:31]      r_first_bad;

    logic        w_beat, w_abort, w_end, w_err, w_good, w_any_flag;
    logic        w_e_data, w_e_seq, w_e_len, w_e_keep;
    logic [0:31] w_exp_pay;
    logic [0:3]  w_cmp_mask;

    assign w_beat     = rx_tvalid & channel_up;
    // channel_up low while a frame is open can only be the first low cycle: the abort returns to IDLE
    assign w_abort    = ~channel_up & (r_state != S_IDLE);
    assign w_exp_pay  = {r_hdr_seq, r_k};
    assign w_cmp_mask = rx_tlast ? rx_tkeep : 4'b1111;
    assign w_err      = w_e_data | w_e_seq | w_e_len | w_e_keep;
    assign w_good     = ~(w_err | ((r_state != S_IDLE) & r_frm_err));
    assign w_any_flag = r_err_data | r_err_seq | r_err_len | r_err_keep | r_err_abort;

    always_comb begin
        w_e_data = 1'b0;
        w_e_seq  = 1'b0;
        w_e_len  = 1'b0;
        w_e_keep = 1'b0;
        w_end    = 1'b0;
        if (w_beat) begin
            case (r_state)
                S_IDLE: begin
                    w_e_data = (rx_data[0:15] != HDR_MAGIC);
                    w_e_seq  = (rx_data[16:31] != r_exp_seq);
                    w_e_keep = (rx_tkeep != 4'b1111);
                    w_end    = rx_tlast;
                end
                S_PAYLOAD: begin
                    w_end = rx_tlast;
                    if (r_k == LP_MAX) begin
                        w_e_len = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < 4; i++) begin
                            if (w_cmp_mask[i] && (rx_data[8*i +: 8] != w_exp_pay[8*i +: 8]))
                                w_e_data = 1'b1;
                        end
                        if (rx_tlast)
                            w_e_keep = !(rx_tkeep inside {4'b1000, 4'b1100, 4'b1110, 4'b1111});
                        else
                            w_e_keep = (rx_tkeep != 4'b1111);
                    end
                end
                default: w_end = rx_tlast;
            endcase
        end
    end

    always_ff @(posedge io_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_exp_seq    <= SEQ_INIT;
            r_hdr_seq    <= '0;
            r_k          <= '0;
            r_frm_err    <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_good <= 1'b0;
            r_ok_cnt     <= '0;
            r_err_cnt    <= '0;
            r_word_cnt   <= '0;
            r_err_data   <= 1'b0;
            r_err_seq    <= 1'b0;
            r_err_len    <= 1'b0;
            r_err_keep   <= 1'b0;
            r_err_abort  <= 1'b0;
            r_first_bad  <= '0;
        end else begin
            r_frame_done <= 1'b0;
            r_frame_good <= 1'b0;

            if (w_abort) begin
                r_state   <= S_IDLE;
                r_frm_err <= 1'b0;
            end else if (w_beat) begin
                case (r_state)
                    S_IDLE: begin
                        r_hdr_seq <= rx_data[16:31];
                        r_exp_seq <= rx_data[16:31] + 16'd1;
                        r_k       <= 16'd1;
                        r_frm_err <= ~rx_tlast & w_err;
                        if (!rx_tlast) r_state <= S_PAYLOAD;
                    end
                    S_PAYLOAD: begin
                        r_k <= r_k + 16'd1;
                        if (rx_tlast) begin
                            r_state   <= S_IDLE;
                            r_frm_err <= 1'b0;
                        end else begin
                            r_frm_err <= r_frm_err | w_err;
                            if (w_e_len) r_state <= S_DISCARD;
                        end
                    end
                    default: begin
                        if (rx_tlast) begin
                            r_state   <= S_IDLE;
                            r_frm_err <= 1'b0;
                        end
                    end
                endcase
            end

            // clear overrides this cycle's statistics and drops any frame result
            if (clr_cnt) begin
                r_exp_seq   <= SEQ_INIT;
                r_ok_cnt    <= '0;
                r_err_cnt   <= '0;
                r_word_cnt  <= '0;
                r_err_data  <= 1'b0;
                r_err_seq   <= 1'b0;
                r_err_len   <= 1'b0;
                r_err_keep  <= 1'b0;
                r_err_abort <= 1'b0;
                r_first_bad <= '0;
            end else begin
                if (w_end || w_abort) begin
                    r_frame_done <= 1'b1;
                    r_frame_good <= w_end & w_good;
                    if (w_end && w_good) begin
                        if (r_ok_cnt != '1) r_ok_cnt <= r_ok_cnt + LP_ONE;
                    end else begin
                        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + LP_ONE;
                    end
                end
                if (w_beat && (r_word_cnt != '1)) r_word_cnt <= r_word_cnt + LP_ONE;
                r_err_data  <= r_err_data  | w_e_data;
                r_err_seq   <= r_err_seq   | w_e_seq;
                r_err_len   <= r_err_len   | w_e_len;
                r_err_keep  <= r_err_keep  | w_e_keep;
                r_err_abort <= r_err_abort | w_abort;
                if ((w_err || w_abort) && !w_any_flag) r_first_bad <= rx_data;
            end
        end
    end

    assign frame_done    = r_frame_done;
    assign frame_good    = r_frame_good;
    assign frame_ok_cnt  = r_ok_cnt;
    assign frame_err_cnt = r_err_cnt;
    assign word_cnt      = r_word_cnt;
    assign err_data      = r_err_data;
    assign err_seq       = r_err_seq;
    assign err_len       = r_err_len;
    assign err_keep      = r_err_keep;
    assign err_abort     = r_err_abort;
    assign first_bad     = r_first_bad;

endmodule

// File: tb/tb_aurora_rx_frame_checker.sv
// Directed bench for aurora_rx_frame_checker: a per-frame model predicts each
// frame_done result and the statistics snapshot that must accompany it.
module tb_aurora_rx_frame_checker;

    localparam logic [15:0] MAGIC = 16'hCAFE;
    localparam int          MAXW  = 8;

    logic        io_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        channel_up = 1'b1;
    logic        clr_cnt = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_tvalid = 1'b0;
    logic [3:0]  rx_tkeep = 4'hF;
    logic        rx_tlast = 1'b0;

    logic        frame_done, frame_good;
    logic [31:0] frame_ok_cnt, frame_err_cnt, word_cnt;
    logic        err_data, err_seq, err_len, err_keep, err_abort;
    logic [31:0] first_bad;

    aurora_rx_frame_checker #(
        .HDR_MAGIC (16'hCAFE),
        .SEQ_INIT  (16'h0000),
        .MAX_WORDS (MAXW),
        .CNT_W     (32)
    ) dut (
        .io_clk        (io_clk),
        .reset_n       (reset_n),
        .channel_up    (channel_up),
        .clr_cnt       (clr_cnt),
        .rx_data       (rx_data),
        .rx_tvalid     (rx_tvalid),
        .rx_tkeep      (rx_tkeep),
        .rx_tlast      (rx_tlast),
        .frame_done    (frame_done),
        .frame_good    (frame_good),
        .frame_ok_cnt  (frame_ok_cnt),
        .frame_err_cnt (frame_err_cnt),
        .word_cnt      (word_cnt),
        .err_data      (err_data),
        .err_seq       (err_seq),
        .err_len       (err_len),
        .err_keep      (err_keep),
        .err_abort     (err_abort),
        .first_bad     (first_bad)
    );

    always #5 io_clk = ~io_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- frame under construction ----------------
    logic [31:0] f_w [16];
    logic [3:0]  f_k [16];
    int          f_n;

    task automatic mk_good(input logic [15:0] seq, input int n);
        f_n = n;
        for (int j = 0; j < 16; j++) begin
            f_w[j] = (j == 0) ? {MAGIC, seq} : {seq, 16'(j)};
            f_k[j] = 4'hF;
        end
    endtask

    // ---------------- model state ----------------
    typedef struct {
        logic        good;
        int unsigned ok;
        int unsigned err;
        int unsigned wc;
        logic [4:0]  flags;   // {data, seq, len, keep, abort}
        logic [31:0] fb;
    } res_t;

    res_t        expq[$];
    int unsigned m_ok, m_err, m_wc;
    logic [4:0]  m_flags;
    logic [31:0] m_fb;
    logic [15:0] m_exp;

    task automatic model_clear();
        m_ok = 0; m_err = 0; m_wc = 0; m_flags = '0; m_fb = '0; m_exp = 16'h0000;
    endtask

    task automatic note(input logic [31:0] d, input logic [4:0] e, inout bit bad);
        if (e != 0) begin
            if (m_flags == 0) m_fb = d;
            m_flags |= e;
            bad = 1'b1;
        end
    endtask

    // Evaluates a whole frame from the pattern rules; nsend words reach the DUT,
    // abort means channel_up falls after them.
    task automatic model_frame(input int nsend, input bit abort);
        bit          bad = 1'b0;
        bit          over = 1'b0;
        logic [15:0] seq = f_w[0][15:0];
        logic [31:0] exp_w;
        logic [4:0]  e;
        bit          last;
        res_t        r;
        e = {f_w[0][31:16] != MAGIC, seq != m_exp, 1'b0, f_k[0] != 4'hF, 1'b0};
        note(f_w[0], e, bad);
        m_exp = seq + 16'd1;
        m_wc++;
        for (int j = 1; j < nsend; j++) begin
            m_wc++;
            if (!over) begin
                if (j + 1 > MAXW) begin
                    over = 1'b1;
                    note(f_w[j], 5'b00100, bad);
                end else begin
                    last  = (j == f_n - 1);
                    exp_w = {seq, 16'(j)};
                    e     = '0;
                    for (int b = 0; b < 4; b++)
                        if ((!last || f_k[j][3-b]) && (f_w[j][31-8*b -: 8] != exp_w[31-8*b -: 8]))
                            e[4] = 1'b1;
                    if (last) e[1] = !(f_k[j] inside {4'b1000, 4'b1100, 4'b1110, 4'b1111});
                    else      e[1] = (f_k[j] != 4'hF);
                    note(f_w[j], e, bad);
                end
            end
        end
        if (abort) note(32'h0, 5'b00001, bad);
        if (bad) m_err++; else m_ok++;
        r.good = !bad; r.ok = m_ok; r.err = m_err; r.wc = m_wc; r.flags = m_flags; r.fb = m_fb;
        expq.push_back(r);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge io_clk);
        #1;
    endtask

    task automatic send(input int nsend, input bit abort);
        model_frame(nsend, abort);
        for (int j = 0; j < nsend; j++) begin
            @(posedge io_clk); #1;
            rx_tvalid = 1'b1;
            rx_data   = f_w[j];
            rx_tkeep  = f_k[j];
            rx_tlast  = !abort && (j == f_n - 1);
        end
        @(posedge io_clk); #1;
        rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tkeep = 4'hF; rx_data = '0;
        if (abort) begin
            channel_up = 1'b0;
            @(posedge io_clk); #1;
            rx_tvalid = 1'b1; rx_data = 32'h12345678;  // ignored: channel is down
            @(posedge io_clk); #1;
            rx_tvalid = 1'b0; rx_data = '0; channel_up = 1'b1;
        end
        idle(2);
    endtask

    task automatic good_frame(input logic [15:0] seq, input int n);
        mk_good(seq, n);
        send(n, 1'b0);
    endtask

    task automatic do_clr();
        @(posedge io_clk); #1 clr_cnt = 1'b1;
        @(posedge io_clk); #1 clr_cnt = 1'b0;
        model_clear();
    endtask

    task automatic drain(input string name);
        idle(3);
        chk(name, 64'(expq.size()), 64'd0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_pulse_flags"}, {frame_done, frame_good, err_data, err_seq, err_len, err_keep, err_abort}, 0);
        chk({name, "_ok"}, frame_ok_cnt, 0);
        chk({name, "_err"}, frame_err_cnt, 0);
        chk({name, "_wc"}, word_cnt, 0);
        chk({name, "_first_bad"}, first_bad, 0);
    endtask

    // ---------------- compare process ----------------
    res_t cr;
    always @(negedge io_clk) begin
        if (reset_n && frame_done) begin
            if (expq.size() == 0) begin
                chk("unexpected_frame_done", 1, 0);
            end else begin
                cr = expq.pop_front();
                chk("frame_good",    frame_good, cr.good);
                chk("frame_ok_cnt",  frame_ok_cnt, cr.ok);
                chk("frame_err_cnt", frame_err_cnt, cr.err);
                chk("word_cnt",      word_cnt, cr.wc);
                chk("flags",         {err_data, err_seq, err_len, err_keep, err_abort}, cr.flags);
                chk("first_bad",     first_bad, cr.fb);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        #12;
        chk_zero("reset");
        @(posedge io_clk); #1 reset_n = 1'b1;
        idle(2);

        // 1: three good 4-word frames
        good_frame(16'd0, 4); good_frame(16'd1, 4); good_frame(16'd2, 4);
        drain("t1_pending");
        chk("t1_ok", frame_ok_cnt, 3);
        chk("t1_err", frame_err_cnt, 0);
        chk("t1_wc", word_cnt, 12);
        chk("t1_flags", {err_data, err_seq, err_len, err_keep, err_abort}, 0);

        // 2: payload corruption in seq 5
        good_frame(16'd3, 4); good_frame(16'd4, 4);
        mk_good(16'd5, 4); f_w[2] = 32'hcafebabe; send(4, 1'b0);
        drain("t2_pending");
        chk("t2_err_data", err_data, 1);
        chk("t2_err_seq", err_seq, 0);
        chk("t2_first_bad", first_bad, 32'hcafebabe);
        chk("t2_err_cnt", frame_err_cnt, 1);
        chk("t2_ok_cnt", frame_ok_cnt, 5);

        // 3: sequence skip then resync
        do_clr();
        idle(1);
        chk_zero("clr");
        good_frame(16'd0, 3); good_frame(16'd2, 3); good_frame(16'd3, 3);
        drain("t3_pending");
        chk("t3_err_seq", err_seq, 1);
        chk("t3_ok", frame_ok_cnt, 2);
        chk("t3_first_bad", first_bad, 32'hcafe0002);

        // 4: tkeep handling and a single-word frame
        mk_good(16'd4, 3); f_w[2] = 32'h0004ffee; f_k[2] = 4'b1100; send(3, 1'b0);
        mk_good(16'd5, 3); f_k[1] = 4'b1110; send(3, 1'b0);
        mk_good(16'd6, 3); f_k[2] = 4'b0110; send(3, 1'b0);
        good_frame(16'd7, 1);
        drain("t4_pending");
        chk("t4_err_keep", err_keep, 1);
        chk("t4_ok", frame_ok_cnt, 4);
        chk("t4_err", frame_err_cnt, 3);

        // 5: overlong frame with MAX_WORDS=8, then an 8-word frame
        do_clr();
        good_frame(16'd0, 10);
        good_frame(16'd1, 8);
        drain("t5_pending");
        chk("t5_flags", {err_data, err_seq, err_len, err_keep, err_abort}, 5'b00100);
        chk("t5_err", frame_err_cnt, 1);
        chk("t5_ok", frame_ok_cnt, 1);
        chk("t5_first_bad", first_bad, 32'h00000008);
        chk("t5_wc", word_cnt, 18);

        // 6: channel drop at word 3, resync, then async reset mid-frame
        mk_good(16'd2, 5); send(3, 1'b1);
        good_frame(16'd3, 4);
        drain("t6_pending");
        chk("t6_err_abort", err_abort, 1);
        chk("t6_err", frame_err_cnt, 2);
        chk("t6_ok", frame_ok_cnt, 2);
        chk("t6_err_seq", err_seq, 0);
        chk("t6_wc", word_cnt, 25);

        mk_good(16'd4, 5);
        for (int j = 0; j < 2; j++) begin
            @(posedge io_clk); #1;
            rx_tvalid = 1'b1; rx_data = f_w[j]; rx_tkeep = 4'hF; rx_tlast = 1'b0;
        end
        #3 reset_n = 1'b0;
        #1 chk_zero("async_reset");
        rx_tvalid = 1'b0; rx_data = '0;
        model_clear();
        @(posedge io_clk); #1 reset_n = 1'b1;
        good_frame(16'd0, 4);
        drain("t7_pending");
        chk("t7_ok", frame_ok_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
